// File: rtl/cook_pkg.sv
// Shared types and constants for the cook controller: FSM state codes, BCD digit type,
// quick-start time and power-level ceiling.
package cook_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // What the datapath does to the digit register this cycle
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_ZERO,
    ACT_KEY,
    ACT_QUICK,
    ACT_DEC
  } act_e;

  typedef logic [3:0] bcd_t;

  localparam int   QUICK_START_SECS = 30;
  localparam bcd_t POWER_MAX        = 4'd10;

  function automatic logic [7:0] secs_bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bcd_t eff_level(input bcd_t pl);
    return (pl == 4'd0 || pl > POWER_MAX) ? POWER_MAX : pl;
  endfunction

endpackage

// File: rtl/cook_controller_if.sv
// Keypad/command inputs and display/status outputs of the cook controller.
// power_level exists only when COOK_POWER_LEVEL_EN is defined.
interface cook_controller_if #(parameter int MIN_DIGITS = 1);
  import cook_pkg::*;
  localparam int W = 4 * (2 + MIN_DIGITS);

  logic         tick;
  logic         key_valid;
  bcd_t         key_digit;
  logic         start;
  logic         stop;
  logic         clear;
  logic         door_closed;
`ifdef COOK_POWER_LEVEL_EN
  logic [3:0]   power_level;
`endif
  logic [W-1:0] digits;
  state_e       state;
  logic         mag_on;
  logic         beep;
  logic         zero;

  modport master (
`ifdef COOK_POWER_LEVEL_EN
    output power_level,
`endif
    output tick, key_valid, key_digit, start, stop, clear, door_closed,
    input  digits, state, mag_on, beep, zero
  );

  modport slave (
`ifdef COOK_POWER_LEVEL_EN
    input  power_level,
`endif
    input  tick, key_valid, key_digit, start, stop, clear, door_closed,
    output digits, state, mag_on, beep, zero
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counter digit: decrements on borrow_in, wrapping 0 -> WRAP with borrow_out.
module bcd_down_digit
  import cook_pkg::*;
#(
  parameter bcd_t WRAP = 4'd9
) (
  input  bcd_t d,
  input  logic borrow_in,
  output bcd_t q,
  output logic borrow_out
);

  always_comb begin
    q          = d;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (d == 4'd0) begin
        q          = WRAP;
        borrow_out = 1'b1;
      end else begin
        q = d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/cook_controller.sv
// Microwave cook timer: BCD keypad entry, countdown, pause/resume and done beep.
// Define COOK_POWER_LEVEL_EN to gate the magnetron with a 10-second duty window.
module cook_controller
  import cook_pkg::*;
#(
  parameter int MIN_DIGITS = 1,
  parameter int BEEP_TICKS = 3
) (
  input  logic clk,
  input  logic rst,
  cook_controller_if.slave bus
);

  localparam int ND = 2 + MIN_DIGITS;

  state_e               state_q, state_n;
  act_e                 act;
  logic [ND-1:0][3:0]   digits_q, digits_n, dec_val;
  logic [ND:0]          borrow;
  logic [3:0]           cnt_q, cnt_n;
  logic                 mag_on_q, mag_on_d, beep_q, beep_d;
  logic                 key_ok, zero, dec_zero;
`ifdef COOK_POWER_LEVEL_EN
  bcd_t                 level_q, level_n;
`endif

  // Ones digit always borrows; seconds tens wraps to 5, every other digit to 9
  assign borrow[0] = 1'b1;
  for (genvar i = 0; i < ND; i++) begin : g_dig
    bcd_down_digit #(.WRAP((i == 1) ? 4'd5 : 4'd9)) u_dig (
      .d          (digits_q[i]),
      .borrow_in  (borrow[i]),
      .q          (dec_val[i]),
      .borrow_out (borrow[i+1])
    );
  end

  assign zero     = (digits_q == '0);
  assign dec_zero = (dec_val == '0) && !borrow[ND];
  assign key_ok   = bus.key_valid && (bus.key_digit <= 4'd9);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // Highest-priority applicable event per state wins; the rest of the cycle is discarded
  always_comb begin
    state_n = state_q;
    act     = ACT_HOLD;
    if (bus.clear) begin
      state_n = ST_IDLE;
      act     = ACT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && bus.door_closed) begin
            state_n = ST_COOK;
            act     = ACT_QUICK;
          end else if (key_ok) begin
            state_n = ST_SET;
            act     = ACT_KEY;
          end
        end
        ST_SET: begin
          if (bus.stop) begin
            state_n = ST_IDLE;
            act     = ACT_ZERO;
          end else if (bus.start && bus.door_closed && !zero) begin
            state_n = ST_COOK;
          end else if (key_ok) begin
            act = ACT_KEY;
          end
        end
        ST_COOK: begin
          if (bus.stop || !bus.door_closed) begin
            state_n = ST_PAUSE;
          end else if (bus.tick) begin
            act = ACT_DEC;
            if (dec_zero) state_n = ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (bus.stop) begin
            state_n = ST_IDLE;
            act     = ACT_ZERO;
          end else if (bus.start && bus.door_closed && !zero) begin
            state_n = ST_COOK;
          end
        end
        ST_DONE: begin
          if (bus.key_valid || bus.start)
            state_n = ST_IDLE;
          else if (bus.tick && cnt_q == 4'(BEEP_TICKS - 1))
            state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
          act     = ACT_ZERO;
        end
      endcase
    end
  end

  always_comb begin
    digits_n = digits_q;
    case (act)
      ACT_ZERO:  digits_n = '0;
      ACT_KEY:   digits_n = {digits_q[ND-2:0], bus.key_digit};
      ACT_QUICK: begin
        digits_n      = '0;
        digits_n[1:0] = secs_bcd(QUICK_START_SECS);
      end
      ACT_DEC:   digits_n = dec_val;
      default:   digits_n = digits_q;
    endcase

    if (state_n != ST_DONE)                     cnt_n = 4'd0;
    else if (state_q == ST_DONE && bus.tick)    cnt_n = cnt_q + 4'd1;
    else                                        cnt_n = cnt_q;

    beep_d = (state_n == ST_DONE);
`ifdef COOK_POWER_LEVEL_EN
    level_n  = (state_q != ST_COOK && state_n == ST_COOK) ? eff_level(bus.power_level) : level_q;
    mag_on_d = (state_n == ST_COOK) && (digits_n[0] < level_n);
`else
    mag_on_d = (state_n == ST_COOK);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      cnt_q    <= 4'd0;
      mag_on_q <= 1'b0;
      beep_q   <= 1'b0;
`ifdef COOK_POWER_LEVEL_EN
      level_q  <= POWER_MAX;
`endif
    end else begin
      digits_q <= digits_n;
      cnt_q    <= cnt_n;
      mag_on_q <= mag_on_d;
      beep_q   <= beep_d;
`ifdef COOK_POWER_LEVEL_EN
      level_q  <= level_n;
`endif
    end
  end

  assign bus.digits = digits_q;
  assign bus.state  = state_q;
  assign bus.mag_on = mag_on_q;
  assign bus.beep   = beep_q;
  assign bus.zero   = zero;

endmodule

// File: tb/tb_cook_controller.sv
// Directed and random checks of cook_controller against a decimal-arithmetic timer model.
module tb_cook_controller;
  import cook_pkg::*;

  localparam int MD = 1;
  localparam int BT = 3;
  localparam int ND = 2 + MD;
  localparam int W  = 4 * ND;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cook_controller_if #(.MIN_DIGITS(MD)) bus();
  cook_controller #(.MIN_DIGITS(MD), .BEEP_TICKS(BT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // Model: time kept as the decimal number shown on the display, e.g. 1:30 -> 130
  int m_n, m_st, m_left, m_lvl;

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int v;
    r = '0;
    v = n;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enter_cook();
    int pl;
    m_st = 2;
`ifdef COOK_POWER_LEVEL_EN
    pl = int'(bus.power_level);
    m_lvl = (pl == 0 || pl > 10) ? 10 : pl;
`else
    pl = 10;
    m_lvl = pl;
`endif
  endtask

  task automatic m_step();
    bit keyok, door;
    int secs;
    keyok = bus.key_valid && (bus.key_digit <= 4'd9);
    door  = bus.door_closed;
    if (rst) begin
      m_n = 0; m_st = 0; m_left = 0;
    end else if (bus.clear) begin
      m_n = 0; m_st = 0;
    end else begin
      case (m_st)
        0: if (bus.start && door) begin m_n = 30; enter_cook(); end
           else if (keyok) begin m_n = (m_n * 10 + int'(bus.key_digit)) % pow10(ND); m_st = 1; end
        1: if (bus.stop) begin m_n = 0; m_st = 0; end
           else if (bus.start && door && m_n != 0) enter_cook();
           else if (keyok) m_n = (m_n * 10 + int'(bus.key_digit)) % pow10(ND);
        2: if (bus.stop || !door) m_st = 3;
           else if (bus.tick) begin
             secs = m_n % 100;
             m_n = (secs > 0) ? m_n - 1 : (m_n / 100 - 1) * 100 + 59;
             if (m_n == 0) begin m_st = 4; m_left = BT; end
           end
        3: if (bus.stop) begin m_n = 0; m_st = 0; end
           else if (bus.start && door && m_n != 0) enter_cook();
        4: if (bus.key_valid || bus.start) m_st = 0;
           else if (bus.tick) begin m_left--; if (m_left == 0) m_st = 0; end
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".digits"}, 32'(bus.digits), 32'(to_bcd(m_n)));
    chk({tag, ".state"},  32'(bus.state),  m_st);
    chk({tag, ".mag_on"}, 32'(bus.mag_on), 32'((m_st == 2) && ((m_n % 10) < m_lvl)));
    chk({tag, ".beep"},   32'(bus.beep),   32'(m_st == 4));
    chk({tag, ".zero"},   32'(bus.zero),   32'(m_n == 0));
  endtask

  // One clock: inputs already driven, model follows the edge, outputs sampled 1 time unit later
  task automatic drive(input string tag, input logic t, kv, input logic [3:0] kd,
                       input logic st, sp, cl);
    bus.tick = t; bus.key_valid = kv; bus.key_digit = kd;
    bus.start = st; bus.stop = sp; bus.clear = cl;
    @(posedge clk);
    m_step();
    #1;
    check_all(tag);
    bus.tick = 0; bus.key_valid = 0; bus.start = 0; bus.stop = 0; bus.clear = 0;
  endtask

  task automatic press(input logic [3:0] k);  drive("key", 0, 1, k, 0, 0, 0); endtask
  task automatic tk();                        drive("tick", 1, 0, 0, 0, 0, 0); endtask
  task automatic idle();                      drive("idle", 0, 0, 0, 0, 0, 0); endtask
  task automatic cmd_start();                 drive("start", 0, 0, 0, 1, 0, 0); endtask
  task automatic cmd_clear();                 drive("clear", 0, 0, 0, 0, 0, 1); endtask

  initial begin
    rst = 1; bus.door_closed = 1; m_lvl = 10;
    bus.tick = 0; bus.key_valid = 0; bus.key_digit = 0;
    bus.start = 0; bus.stop = 0; bus.clear = 0;
`ifdef COOK_POWER_LEVEL_EN
    bus.power_level = 4'd0;
`endif
    m_n = 0; m_st = 0; m_left = 0;
    drive("rst", 0, 0, 0, 1, 0, 0);
    drive("rst", 1, 1, 4'd5, 0, 0, 0);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_digits", 32'(bus.digits), 0);
    rst = 0;
    idle();

    // 1:30 entry and countdown across the minute boundary
    press(1); press(3); press(0);
    chk("key_130", 32'(bus.digits), 32'h130);
    cmd_start();
    chk("cook_130.state", 32'(bus.state), 2);
    chk("cook_130.mag", 32'(bus.mag_on), 1);
    tk();
    chk("tick_129", 32'(bus.digits), 32'h129);
    for (int i = 0; i < 29; i++) tk();
    chk("tick_100", 32'(bus.digits), 32'h100);
    tk();
    chk("tick_059", 32'(bus.digits), 32'h059);
    press(7);
    chk("key_in_cook", 32'(bus.digits), 32'h059);
    cmd_clear();

    // 0:02 to DONE and the beep window
    press(2); cmd_start(); tk(); tk();
    chk("done.state", 32'(bus.state), 4);
    chk("done.mag", 32'(bus.mag_on), 0);
    chk("done.beep", 32'(bus.beep), 1);
    idle(); tk(); idle(); tk();
    chk("beep_2", 32'(bus.beep), 1);
    tk();
    chk("beep_end.state", 32'(bus.state), 0);
    chk("beep_end.beep", 32'(bus.beep), 0);

    // Door open mid-cook at 0:45
    press(4); press(5); cmd_start();
    bus.door_closed = 0; idle();
    chk("door.state", 32'(bus.state), 3);
    tk(); tk();
    chk("door.held", 32'(bus.digits), 32'h045);
    bus.door_closed = 1; cmd_start();
    chk("resume.state", 32'(bus.state), 2);
    chk("resume.digits", 32'(bus.digits), 32'h045);
    cmd_clear();

    // stop+tick at 0:10, then clear+start
    press(1); press(0); cmd_start();
    drive("stop_tick", 1, 0, 0, 0, 1, 0);
    chk("stop_tick.state", 32'(bus.state), 3);
    chk("stop_tick.digits", 32'(bus.digits), 32'h010);
    drive("clr_start", 0, 0, 0, 1, 0, 1);
    chk("clr_start.state", 32'(bus.state), 0);
    chk("clr_start.digits", 32'(bus.digits), 0);

    // Quick start, and start with the door open
    cmd_start();
    chk("quick.digits", 32'(bus.digits), 32'h030);
    chk("quick.state", 32'(bus.state), 2);
    cmd_clear();
    bus.door_closed = 0; cmd_start();
    chk("open_start", 32'(bus.state), 0);
    bus.door_closed = 1;

    // Invalid key, 0:90 natural countdown, DONE exit by key, stop in SET
    press(9); press(4'hB);
    chk("bad_key", 32'(bus.digits), 32'h009);
    press(0); cmd_start(); tk();
    chk("tick_089", 32'(bus.digits), 32'h089);
    cmd_clear();
    press(1); cmd_start(); tk(); press(5);
    chk("done_key.state", 32'(bus.state), 0);
    chk("done_key.digits", 32'(bus.digits), 0);
    press(3); drive("stop_set", 0, 0, 0, 0, 1, 0);
    chk("stop_set", 32'(bus.state), 0);

    // Reset mid-cook
    cmd_start(); rst = 1;
    drive("rst_cook", 1, 0, 0, 1, 0, 0);
    chk("rst_cook.mag", 32'(bus.mag_on), 0);
    rst = 0;

`ifdef COOK_POWER_LEVEL_EN
    bus.power_level = 4'd3;
    press(2); press(0); cmd_start();
    for (int i = 0; i < 19; i++) begin
      chk("pwr3", 32'(bus.mag_on), 32'(((20 - i) % 10) < 3));
      tk();
    end
    cmd_clear();
    bus.power_level = 4'd0;
    press(1); press(5); cmd_start();
    for (int i = 0; i < 12; i++) begin
      chk("pwr0", 32'(bus.mag_on), 1);
      tk();
    end
    cmd_clear();
`endif

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 19) == 0) bus.door_closed = ~bus.door_closed;
`ifdef COOK_POWER_LEVEL_EN
      bus.power_level = 4'($urandom_range(0, 15));
`endif
      drive("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 199) == 0));
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cook_controller.md
COOK_CONTROLLER -- requirements
Module: cook_controller

Interface
REQ-001 Parameter MIN_DIGITS, default 1, is the number of BCD minute digits (legal 1..3).
REQ-002 Parameter BEEP_TICKS, default 3, is the number of tick periods the done beep lasts (legal 1..15).
REQ-003 clk  in  1  sole clock, rising edge; reset is synchronous and active-high.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 tick  in  1  one-cycle 1 Hz enable pulse.
REQ-006 key_valid  in  1  one-cycle pulse qualifying key_digit.
REQ-007 key_digit  in  4  BCD keypad digit.
REQ-008 start, stop, clear  in  1 each  one-cycle active-high command pulses.
REQ-009 door_closed  in  1  level, 1 = door shut.
REQ-010 power_level  in  4  duty setting (present only with the power-level feature, REQ-031).
REQ-011 digits  out  4*(2+MIN_DIGITS)  BCD time, [3:0] = seconds ones, [7:4] = seconds tens, upper nibbles = minutes, least-significant first.
REQ-012 state  out  3  current FSM state code.
REQ-013 mag_on  out  1  magnetron enable, registered.
REQ-014 beep  out  1  done indication, registered.
REQ-015 zero  out  1  combinational, high when all digits are 0.

Function
REQ-016 The FSM shall have the states IDLE=0, SET=1, COOK=2, PAUSE=3 and DONE=4.
REQ-017 Key entry (key_valid with key_digit<=9, in IDLE or SET only) shall shift digits left by one nibble, insert key_digit at seconds ones, drop the top nibble, and go to SET.
REQ-018 Key entry shall ignore key_digit>9 and shall ignore keys in COOK, PAUSE and DONE (except the DONE exit, REQ-024).
REQ-019 start in SET or PAUSE with door_closed=1 and zero=0 shall enter COOK; start with the door open shall be ignored.
REQ-020 start in IDLE with door_closed=1 shall load 0:30 and enter COOK (quick start).
REQ-021 In COOK, each tick shall decrement digits with BCD borrow, updating in the same cycle as the tick:
- ones 0 -> 9 and borrow;
- seconds tens 0 with borrow -> 5;
- minute digit 0 with borrow -> 9.
REQ-022 Entered seconds-tens values above 5 shall count down naturally (e.g. 0:90 -> 0:89).
REQ-023 A tick that makes digits zero shall enter DONE and clear mag_on on the next edge.
REQ-024 In DONE, beep shall be high for BEEP_TICKS ticks, after which the FSM goes to IDLE; key_valid, start or clear in DONE shall go to IDLE immediately.
REQ-025 stop or door_closed=0 in COOK shall enter PAUSE with digits held.
REQ-026 stop in PAUSE or SET shall zero digits and go to IDLE.
REQ-027 clear in any state shall zero digits and go to IDLE, with mag_on=0 and beep=0.
REQ-028 Same-cycle priority shall be clear > stop > door open > start > tick > key; a lower-priority event in the same cycle is discarded (no decrement on a stop+tick cycle).
REQ-029 Without the power-level feature, mag_on shall equal (state==COOK), registered, asserting one cycle after start is accepted.

Reset
REQ-030 On rst: digits=0, state=IDLE, mag_on=0, beep=0 and the beep counter=0.
- Reset mid-COOK shall drop mag_on on the same edge.
- rst overrides every input.

Configuration
REQ-031 Macro COOK_POWER_LEVEL_EN.
- Defined: the power_level port exists and is sampled into a register when COOK is entered; a value of 0 or greater than 10 is treated as 10. In COOK, mag_on=1 only while seconds ones < sampled level, giving a 10-second duty window.
- Undefined: the port is absent and REQ-029 applies.

Structure
REQ-032 Package cook_pkg shall hold the state enum, the 4-bit bcd_t type, the QUICK_START_SECS constant (30) and the power-level maximum (10).
REQ-033 Sub-module bcd_down_digit (one digit, parametrised wrap value 9 or 5, with borrow_in and borrow_out) shall be instantiated 2+MIN_DIGITS times via generate.

Verification
REQ-034 Keys 1,3,0, start, door closed, MIN_DIGITS=1 -> digits 1:30, state COOK; after 1 tick -> 1:29; after 30 ticks total -> 1:00, then 0:59.
REQ-035 0:02 cooking, 2 ticks -> state DONE, mag_on=0, beep high for 3 ticks, then IDLE.
REQ-036 Door opened mid-COOK at 0:45 -> PAUSE, digits 0:45 held, ticks ignored; door closed plus start -> COOK resumes at 0:45.
REQ-037 stop and tick in the same cycle at 0:10 -> PAUSE at 0:10; clear and start in the same cycle -> IDLE, digits 0.
REQ-038 start in IDLE, door closed -> digits 0:30, COOK; start with door open -> remains IDLE.
REQ-039 COOK_POWER_LEVEL_EN, power_level=3, 0:20 -> mag_on high while seconds ones are 0..2 and low otherwise; power_level=0 -> mag_on continuously high.
